// File: rtl/seg7_to_bcd_capture.sv
// Captures multiplexed 7-segment digit strobes into BCD nibbles once each
// strobe/pattern pair has been held stable for STABLE_CYCLES clock edges.
module seg7_to_bcd_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_sel,
  output logic [15:0] bcd,
  output logic [3:0]  err,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        frame_valid
);

  localparam int unsigned NDIG = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned SEGW = 7;
  localparam int unsigned CW   = 4;
  localparam int unsigned IW   = 2;

  localparam logic [CW-1:0]   CNT_SAT   = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_CAP   = CW'(STABLE_CYCLES - 2);
  localparam logic [SEGW-1:0] SEG_BLANK = 7'h7F;
  localparam logic [DW-1:0]   CODE_BLNK = 4'hF;
  localparam logic [DW-1:0]   CODE_ILL  = 4'hE;

  logic [NDIG-1:0] smp_sel;
  logic [SEGW-1:0] smp_seg;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt_c;
  logic [NDIG-1:0] seen;

  logic            onehot_c;
  logic            same_c;
  logic            capture_c;
  logic            frame_done_c;
  logic [IW-1:0]   idx_c;
  logic [DW-1:0]   code_c;
  logic            illegal_c;

  // Stability tracking: restart on any change or illegal strobe, saturate when held
  always_comb begin
    onehot_c  = (dig_sel != '0) && ((dig_sel & (dig_sel - 4'd1)) == '0);
    same_c    = (dig_sel == smp_sel) && (seg_n == smp_seg);
    cnt_nxt_c = '0;
    if (onehot_c && same_c) begin
      if (cnt < CNT_SAT) cnt_nxt_c = cnt + 4'd1;
      else               cnt_nxt_c = cnt;
    end
    capture_c    = onehot_c && same_c && (cnt == CNT_CAP);
    frame_done_c = capture_c && ((seen | dig_sel) == 4'hF);
  end

  // Strobe to digit index
  always_comb begin
    idx_c = '0;
    case (dig_sel)
      4'b0001: idx_c = 2'd0;
      4'b0010: idx_c = 2'd1;
      4'b0100: idx_c = 2'd2;
      4'b1000: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase
  end

  // Active-low gfedcba pattern to digit code
  always_comb begin
    code_c    = CODE_ILL;
    illegal_c = 1'b0;
    case (seg_n)
      7'h40: code_c = 4'd0;
      7'h79: code_c = 4'd1;
      7'h24: code_c = 4'd2;
      7'h30: code_c = 4'd3;
      7'h19: code_c = 4'd4;
      7'h12: code_c = 4'd5;
      7'h02: code_c = 4'd6;
      7'h78: code_c = 4'd7;
      7'h00: code_c = 4'd8;
      7'h10: code_c = 4'd9;
      7'h7F: code_c = CODE_BLNK;
      default: begin
        code_c    = CODE_ILL;
        illegal_c = 1'b1;
      end
    endcase
  end

  // Input sample registers and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_sel <= '0;
      smp_seg <= SEG_BLANK;
      cnt     <= '0;
    end else begin
      smp_sel <= dig_sel;
      smp_seg <= seg_n;
      cnt     <= cnt_nxt_c;
    end
  end

  // Digit registers, error flags, update and frame tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd         <= 16'hFFFF;
      err         <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      frame_valid <= 1'b0;
      seen        <= '0;
    end else begin
      upd         <= capture_c;
      frame_valid <= frame_done_c;
      if (capture_c) begin
        upd_idx <= idx_c;
        for (int i = 0; i < NDIG; i++) begin
          if (dig_sel[i]) begin
            bcd[i*DW +: DW] <= code_c;
            err[i]          <= illegal_c;
          end
        end
        if (frame_done_c) seen <= '0;
        else              seen <= seen | dig_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Self-checking bench for seg7_to_bcd_capture: directed scenarios plus random
// strobe/pattern holds checked against a run-length reference model.
module tb_seg7_to_bcd_capture;

  localparam int unsigned SC = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_n, seg_n2;
  logic [3:0]  dig_sel, dig_sel2;
  logic [15:0] bcd, bcd2;
  logic [3:0]  err, err2;
  logic        upd, upd2;
  logic [1:0]  upd_idx, upd_idx2;
  logic        frame_valid, frame_valid2;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // reference model state
  int          hold;
  logic [3:0]  h_sel;
  logic [6:0]  h_seg;
  logic [15:0] m_bcd;
  logic [3:0]  m_err;
  logic        m_upd;
  logic [1:0]  m_idx;
  logic        m_fv;
  logic [3:0]  m_seen;

  logic [6:0] pats [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] bad_sel [0:7] = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};

  seg7_to_bcd_capture #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_sel(dig_sel),
    .bcd(bcd), .err(err), .upd(upd), .upd_idx(upd_idx),
    .frame_valid(frame_valid)
  );

  seg7_to_bcd_capture #(.STABLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n2), .dig_sel(dig_sel2),
    .bcd(bcd2), .err(err2), .upd(upd2), .upd_idx(upd_idx2),
    .frame_valid(frame_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // returns {err, code}
  function automatic logic [4:0] ref_decode(input logic [6:0] g);
    for (int i = 0; i < 10; i++)
      if (g == pats[i]) return {1'b0, 4'(i)};
    if (g == 7'h7F) return 5'h0F;
    return 5'h1E;
  endfunction

  task automatic model_reset();
    hold = 0; h_sel = 4'h0; h_seg = 7'h7F;
    m_bcd = 16'hFFFF; m_err = 4'h0; m_upd = 1'b0; m_idx = 2'd0;
    m_fv = 1'b0; m_seen = 4'h0;
  endtask

  // Capture happens on the SC-th consecutive edge that sees the same legal input
  task automatic model_edge(input logic [3:0] s, input logic [6:0] g);
    logic       legal;
    logic [4:0] d;
    int         idx;
    legal = ($countones(s) == 1);
    if (legal && hold > 0 && s == h_sel && g == h_seg) hold++;
    else hold = legal ? 1 : 0;
    h_sel = s; h_seg = g;
    m_upd = 1'b0; m_fv = 1'b0;
    if (hold == SC) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (s[i]) idx = i;
      d = ref_decode(g);
      m_bcd[idx*4 +: 4] = d[3:0];
      m_err[idx] = d[4];
      m_upd = 1'b1;
      m_idx = 2'(idx);
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        m_fv = 1'b1;
        m_seen = 4'h0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".upd"}, 16'(upd), 16'(m_upd));
    chk({tag, ".frame_valid"}, 16'(frame_valid), 16'(m_fv));
    chk({tag, ".bcd"}, bcd, m_bcd);
    chk({tag, ".err"}, 16'(err), 16'(m_err));
    if (m_upd) chk({tag, ".upd_idx"}, 16'(upd_idx), 16'(m_idx));
  endtask

  task automatic tick(input string tag, input logic [3:0] s, input logic [6:0] g);
    dig_sel = s; seg_n = g;
    @(posedge clk);
    model_edge(s, g);
    #1;
    check_all(tag);
  endtask

  task automatic hold_n(input string tag, input logic [3:0] s, input logic [6:0] g, input int n);
    for (int k = 0; k < n; k++) tick(tag, s, g);
  endtask

  // Reset pulse placed between clock edges to exercise the asynchronous path
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int unsigned r, n;
    logic [3:0]  s;
    logic [6:0]  g;

    rst_n = 1'b0; dig_sel = 4'h0; seg_n = 7'h7F; dig_sel2 = 4'h0; seg_n2 = 7'h7F;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // single digit capture, then no re-capture while held
    hold_n("d0_hold", 4'b0001, 7'h24, 4);
    chk("d0_nib", 16'(bcd[3:0]), 16'h2);
    hold_n("d0_sat", 4'b0001, 7'h24, 4);

    // full frame 9531
    hold_n("frame_d0", 4'b0001, 7'h79, 4);
    hold_n("frame_d1", 4'b0010, 7'h30, 4);
    hold_n("frame_d2", 4'b0100, 7'h12, 4);
    hold_n("frame_d3", 4'b1000, 7'h10, 4);
    chk("frame_bcd", bcd, 16'h9531);

    // illegal pattern then blank
    hold_n("ill_d2", 4'b0100, 7'h55, 4);
    chk("ill_err", 16'(err[2]), 16'h1);
    hold_n("blank_d2", 4'b0100, 7'h7F, 4);
    chk("blank_nib", 16'(bcd[11:8]), 16'hF);

    // unstable pattern and multi-hot strobe never capture
    pulse_reset("rst_a");
    for (int k = 0; k < 4; k++) begin
      hold_n("toggle40", 4'b0001, 7'h40, 2);
      hold_n("toggle79", 4'b0001, 7'h79, 2);
    end
    hold_n("multihot", 4'b0011, 7'h40, 10);
    chk("nocap_bcd", bcd, 16'hFFFF);

    // reset mid-hold aborts capture
    hold_n("pre_rst", 4'b1000, 7'h00, 3);
    pulse_reset("rst_mid");
    hold_n("post_rst", 4'b1000, 7'h00, 4);
    chk("post_rst_nib", 16'(bcd[15:12]), 16'h8);

    // random holds
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        pulse_reset("rnd_rst");
        continue;
      end
      if (r == 1) s = bad_sel[$urandom_range(0, 7)];
      else        s = 4'(1 << $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 6)       g = pats[$urandom_range(0, 9)];
      else if (r < 8)  g = 7'h7F;
      else             g = 7'($urandom);
      n = $urandom_range(1, 6);
      hold_n("rnd", s, g, int'(n));
    end

    // short stability window instance
    dig_sel2 = 4'b0010; seg_n2 = 7'h78;
    @(posedge clk); #1;
    chk("sc2_e0_upd", 16'(upd2), 16'h0);
    @(posedge clk); #1;
    chk("sc2_e1_upd", 16'(upd2), 16'h1);
    chk("sc2_e1_idx", 16'(upd_idx2), 16'h1);
    chk("sc2_e1_bcd", bcd2, 16'hFF7F);
    chk("sc2_e1_err", 16'(err2), 16'h0);
    @(posedge clk); #1;
    chk("sc2_e2_upd", 16'(upd2), 16'h0);
    chk("sc2_e2_fv", 16'(frame_valid2), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
